// File: rtl/ps2_tx_if.sv
// ps2_tx_if: command handshake and open-drain pad signals for the PS/2 host transmitter
interface ps2_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ps2c;
    logic       ps2d;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx_err;
    modport master (
        output tx_start, tx_data, ps2c, ps2d,
        input  ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err
    );
    modport slave (
        input  tx_start, tx_data, ps2c, ps2d,
        output ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err
    );
endinterface

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter (inhibit, request-to-send, 11-bit shift, ack check)
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic     clk,
    input  logic     reset_n,
    ps2_tx_if.slave  bus
);
    localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;
    state_t        state_q, state_d;
    logic [1:0]    c_sync_q, d_sync_q;
    logic [7:0]    filt_q;
    logic          clk_f_q, clk_f_d;
    logic [10:0]   frame_q, frame_d;
    logic [3:0]    n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack_err_q, ack_err_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          sd, fall, start, timeout, idle_lines;
    assign sd         = d_sync_q[1];
    assign clk_f_d    = &filt_q ? 1'b1 : ~|filt_q ? 1'b0 : clk_f_q;
    assign fall       = clk_f_q & ~clk_f_d;
    assign start      = state_q == IDLE && bus.tx_start && !done_q;
    assign idle_lines = clk_f_q && sd;
    assign timeout    = (state_q == REQ || state_q == SEND || state_q == ACK || state_q == WAIT_IDLE)
                        && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            c_sync_q  <= 2'b11;
            d_sync_q  <= 2'b11;
            filt_q    <= 8'hff;
            clk_f_q   <= 1'b1;
            frame_q   <= '1;
            n_q       <= '0;
            cnt_q     <= '0;
            ack_err_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_sync_q  <= {c_sync_q[0], bus.ps2c};
            d_sync_q  <= {d_sync_q[0], bus.ps2d};
            filt_q    <= {filt_q[6:0], c_sync_q[1]};
            clk_f_q   <= clk_f_d;
            frame_q   <= frame_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (timeout) state_d = IDLE;
        else case (state_q)
            IDLE:      if (start) state_d = INHIBIT;
            INHIBIT:   if (cnt_q == CW'(INHIBIT_CYCLES - 1)) state_d = REQ;
            REQ:       state_d = SEND;
            SEND:      if (n_q == 4'd10) state_d = ACK;
            ACK:       if (fall) state_d = WAIT_IDLE;
            WAIT_IDLE: if (idle_lines) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end
    // Frame carries the start bit in bit 0 so SEND can drive it before the first device edge
    always_comb begin
        frame_d   = frame_q;
        n_d       = n_q;
        ack_err_d = ack_err_q;
        cnt_d     = state_q == IDLE ? cnt_q : cnt_q + CW'(1);
        done_d    = timeout || (state_q == WAIT_IDLE && idle_lines);
        err_d     = timeout ? 1'b1 : done_d ? ack_err_q : err_q;
        if (start) begin
            frame_d   = {1'b1, ~^bus.tx_data, bus.tx_data, 1'b0};
            n_d       = '0;
            cnt_d     = '0;
            ack_err_d = 1'b1;
        end
        if (state_q == INHIBIT && state_d == REQ) cnt_d = '0;
        if (state_q == SEND && fall) begin
            frame_d = {1'b1, frame_q[10:1]};
            n_d     = n_q + 4'd1;
        end
        if (state_q == ACK && fall) ack_err_d = sd;
    end
    always_comb begin
        bus.ps2c_oe      = state_q == INHIBIT || state_q == REQ;
        bus.ps2d_oe      = state_q == REQ || (state_q == SEND && !frame_q[0]);
        bus.tx_busy      = state_q != IDLE || done_q;
        bus.tx_done_tick = done_q;
        bus.tx_err       = err_q;
    end
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed bench with an open-drain device model for the PS/2 host transmitter
module tb_ps2_tx;
    logic clk = 1'b0;
    logic reset_n;
    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic last_err = 1'b0;
    ps2_tx_if m();
    ps2_tx_if t();
    always #5 clk = ~clk;
    assign m.ps2c = ~(m.ps2c_oe | dev_c_low);
    assign m.ps2d = ~(m.ps2d_oe | dev_d_low);
    assign t.ps2c = ~t.ps2c_oe;
    assign t.ps2d = ~t.ps2d_oe;
    ps2_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) u_dut (.clk(clk), .reset_n(reset_n), .bus(m));
    ps2_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(500))  u_to  (.clk(clk), .reset_n(reset_n), .bus(t));
    always @(negedge clk) if (m.tx_done_tick === 1'b1) begin
        done_cnt++;
        last_err = m.tx_err;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic start_m(input logic [7:0] d);
        @(posedge clk); #1 m.tx_start = 1'b1; m.tx_data = d;
        @(posedge clk); #1 m.tx_start = 1'b0;
    endtask
    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = m.ps2c_oe === 1'b0 && m.ps2d_oe === 1'b1;
        end
    endtask
    // Device samples the data line at the end of each clock-high phase; edge 11 carries the ack
    task automatic device(input bit ack, output logic [10:0] bits);
        bit ok;
        bits = 'x;
        wait_send(ok);
        check("dev_send_seen", 32'(ok), 1);
        if (ok) begin
            repeat (30) @(negedge clk);
            for (int i = 0; i < 11; i++) begin
                bits[i] = m.ps2d;
                dev_d_low = ack && i == 10;
                dev_c_low = 1'b1;
                repeat (20) @(negedge clk);
                dev_c_low = 1'b0;
                dev_d_low = 1'b0;
                repeat (20) @(negedge clk);
            end
        end
    endtask
    task automatic inhibit_window(output int c_hi, output int d_first);
        c_hi = 0;
        d_first = 0;
        while (m.ps2c_oe === 1'b1 && c_hi < 100) begin
            c_hi++;
            if (m.ps2d_oe === 1'b1 && d_first == 0) d_first = c_hi;
            @(posedge clk); #1;
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end
    initial begin
        logic [10:0] bits;
        int d0, c_hi, d_first, k;
        bit ok;
        reset_n = 1'b0;
        m.tx_start = 1'b0; m.tx_data = 8'h00;
        t.tx_start = 1'b0; t.tx_data = 8'h00;
        repeat (2) @(posedge clk); #1;
        check("rst_c_oe", 32'(m.ps2c_oe), 0);
        check("rst_d_oe", 32'(m.ps2d_oe), 0);
        check("rst_busy", 32'(m.tx_busy), 0);
        check("rst_done", 32'(m.tx_done_tick), 0);
        check("rst_err", 32'(m.tx_err), 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        d0 = done_cnt;
        start_m(8'hED);
        device(1'b1, bits);
        repeat (20) @(negedge clk);
        check("ed_bits", 32'(bits), 32'h7DA);
        check("ed_done_cnt", done_cnt - d0, 1);
        check("ed_err", 32'(last_err), 0);
        check("ed_busy_after", 32'(m.tx_busy), 0);
        d0 = done_cnt;
        start_m(8'hF4);
        check("f4_busy_t1", 32'(m.tx_busy), 1);
        inhibit_window(c_hi, d_first);
        check("f4_c_oe_cycles", c_hi, 21);
        check("f4_d_oe_first", d_first, 21);
        device(1'b1, bits);
        repeat (20) @(negedge clk);
        check("f4_bits", 32'(bits), 32'h5E8);
        check("f4_parity", 32'(bits[9]), 0);
        check("f4_err", 32'(last_err), 0);
        check("f4_done_cnt", done_cnt - d0, 1);
        start_m(8'h00);
        inhibit_window(c_hi, d_first);
        check("z_c_oe_cycles", c_hi, 21);
        device(1'b1, bits);
        repeat (20) @(negedge clk);
        check("z_bits", 32'(bits), 32'h600);
        check("z_parity", 32'(bits[9]), 1);
        d0 = done_cnt;
        start_m(8'hED);
        device(1'b0, bits);
        repeat (20) @(negedge clk);
        check("noack_done_cnt", done_cnt - d0, 1);
        check("noack_err", 32'(last_err), 1);
        check("noack_busy", 32'(m.tx_busy), 0);
        d0 = done_cnt;
        start_m(8'hED);
        fork
            device(1'b1, bits);
            begin
                repeat (200) @(posedge clk);
                #1 m.tx_start = 1'b1; m.tx_data = 8'h55;
                @(posedge clk); #1 m.tx_start = 1'b0;
            end
        join
        repeat (100) @(negedge clk);
        check("mid_bits", 32'(bits), 32'h7DA);
        check("mid_done_cnt", done_cnt - d0, 1);
        check("mid_err", 32'(last_err), 0);
        check("mid_busy", 32'(m.tx_busy), 0);
        check("mid_c_oe", 32'(m.ps2c_oe), 0);
        @(posedge clk); #1 t.tx_start = 1'b1; t.tx_data = 8'hF4;
        @(posedge clk); #1 t.tx_start = 1'b0;
        k = 1;
        while (t.tx_done_tick !== 1'b1 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check("to_latency", k, 521);
        check("to_err", 32'(t.tx_err), 1);
        check("to_c_oe", 32'(t.ps2c_oe), 0);
        check("to_d_oe", 32'(t.ps2d_oe), 0);
        check("to_busy_tick", 32'(t.tx_busy), 1);
        @(posedge clk); #1;
        check("to_busy_after", 32'(t.tx_busy), 0);
        start_m(8'hED);
        wait_send(ok);
        check("rst_send_seen", 32'(ok), 1);
        repeat (30) @(negedge clk);
        repeat (4) begin
            dev_c_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (20) @(negedge clk);
        end
        dev_c_low = 1'b1;
        repeat (15) @(negedge clk);
        check("mid_rst_busy_pre", 32'(m.tx_busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_c_oe", 32'(m.ps2c_oe), 0);
        check("mid_rst_d_oe", 32'(m.ps2d_oe), 0);
        check("mid_rst_busy", 32'(m.tx_busy), 0);
        dev_c_low = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (30) @(posedge clk);
        d0 = done_cnt;
        start_m(8'hFF);
        device(1'b1, bits);
        repeat (20) @(negedge clk);
        check("ff_bits", 32'(bits), 32'h7FE);
        check("ff_parity", 32'(bits[9]), 1);
        check("ff_err", 32'(last_err), 0);
        check("ff_done_cnt", done_cnt - d0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
